// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_stage
//  Purpose  : Pipeline IF stage: PC sequencing, redirect/stall/halt handling,
//             bubble generation and accepted-fetch counting.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus4_F,
    output logic [31:0] InstWord_F,
    output logic        nop_F,
    output logic        nop_D,
    output logic        halted,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    localparam logic [1:0]  S_START  = 2'd0;
    localparam logic [1:0]  S_FETCH  = 2'd1;
    localparam logic [1:0]  S_HALTED = 2'd2;
    localparam logic [31:0] c_PC_INC = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic        r_addr_err;
    logic        r_halted;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_fetch_count_nxt;
    logic        w_addr_err_nxt;
    logic        w_halted_nxt;
    logic        w_in_fetch;
    logic [31:0] w_pc_plus4;
    logic        w_redirect_misaligned;

    assign w_in_fetch            = (r_state == S_FETCH);
    assign w_pc_plus4            = r_pc + c_PC_INC;
    assign w_redirect_misaligned = (redirect_addr[1:0] != 2'b00);

    // Rules in FETCH are evaluated in strict priority: halt, redirect, stall,
    // advance, wait. START and HALTED ignore every pipeline input.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_fetch_count_nxt = r_fetch_count;
        w_addr_err_nxt    = r_addr_err;
        w_halted_nxt      = r_halted;
        case (r_state)
            S_START: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (halt) begin
                    w_state_nxt  = S_HALTED;
                    w_halted_nxt = 1'b1;
                end else if (redirect_valid) begin
                    if (w_redirect_misaligned) begin
                        w_addr_err_nxt = 1'b1;
                        w_state_nxt    = S_HALTED;
                        w_halted_nxt   = 1'b1;
                    end else begin
                        w_pc_nxt = redirect_addr;
                    end
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (imem_ready) begin
                    w_pc_nxt          = w_pc_plus4;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                end
            end
            S_HALTED: begin
                w_state_nxt  = S_HALTED;
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt  = S_HALTED;
                w_halted_nxt = 1'b1;
            end
        endcase
    end

    // The pipeline commits on the falling edge of CLK.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_START;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
            r_addr_err    <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
            r_addr_err    <= w_addr_err_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign imem_req    = w_in_fetch;
    assign imem_addr   = r_pc;
    assign PC_F        = r_pc;
    assign PC_Plus4_F  = w_pc_plus4;
    assign InstWord_F  = (w_in_fetch && imem_ready) ? imem_rdata : NOP_WORD;
    assign nop_F       = !w_in_fetch || !imem_ready || redirect_valid;
    assign nop_D       = w_in_fetch && redirect_valid;
    assign halted      = r_halted;
    assign addr_err    = r_addr_err;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_stage
//  Purpose  : Directed vector bench for instr_fetch_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] ra;
        logic        halt;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_nopf;
        logic        e_nopd;
        logic [31:0] e_inst;
        logic        e_halted;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC_F;
    logic [31:0] PC_Plus4_F;
    logic [31:0] InstWord_F;
    logic        nop_F;
    logic        nop_D;
    logic        halted;
    logic        addr_err;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_stage dut (
        .CLK            (CLK),
        .RST            (RST),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .PC_F           (PC_F),
        .PC_Plus4_F     (PC_Plus4_F),
        .InstWord_F     (InstWord_F),
        .nop_F          (nop_F),
        .nop_D          (nop_D),
        .halted         (halted),
        .addr_err       (addr_err),
        .fetch_count    (fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t v);
        logic [31:0] pc4;
        pc4 = v.e_pc + 32'd4;
        chk({tag, " PC_F"},        PC_F,        v.e_pc);
        chk({tag, " imem_addr"},   imem_addr,   v.e_pc);
        chk({tag, " PC_Plus4_F"},  PC_Plus4_F,  pc4);
        chk({tag, " imem_req"},    {31'd0, imem_req}, {31'd0, v.e_req});
        chk({tag, " nop_F"},       {31'd0, nop_F},    {31'd0, v.e_nopf});
        chk({tag, " nop_D"},       {31'd0, nop_D},    {31'd0, v.e_nopd});
        chk({tag, " InstWord_F"},  InstWord_F,  v.e_inst);
        chk({tag, " halted"},      {31'd0, halted},   {31'd0, v.e_halted});
        chk({tag, " fetch_count"}, fetch_count, v.e_cnt);
        chk({tag, " addr_err"},    {31'd0, addr_err}, {31'd0, v.e_err});
    endtask

    // Inputs change just after a falling edge; outputs are sampled on the
    // rising edge, halfway through the cycle, before the next commit.
    task automatic apply_vec(input string tag, input vec_t v);
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_addr  = v.ra;
        halt           = v.halt;
        imem_ready     = v.rdy;
        imem_rdata     = v.rdata;
        @(posedge CLK);
        chk_outputs(tag, v);
        @(negedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'd0;
        halt           = 1'b0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'd0;
    endtask

    // Reset takes effect immediately; release lands just after a falling edge
    // so the following cycle is the START bubble.
    task automatic do_reset(input string tag);
        RST = 1'b0;
        #1;
        chk({tag, " rst PC_F"},        PC_F,        32'h0);
        chk({tag, " rst PC_Plus4_F"},  PC_Plus4_F,  32'h4);
        chk({tag, " rst fetch_count"}, fetch_count, 32'h0);
        chk({tag, " rst addr_err"},    {31'd0, addr_err}, 32'd0);
        chk({tag, " rst halted"},      {31'd0, halted},   32'd0);
        chk({tag, " rst imem_req"},    {31'd0, imem_req}, 32'd0);
        chk({tag, " rst nop_F"},       {31'd0, nop_F},    32'd1);
        chk({tag, " rst nop_D"},       {31'd0, nop_D},    32'd0);
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        #1;
        RST = 1'b1;
    endtask

    vec_t vecs [15];
    vec_t seq_wrap [6];
    vec_t seq_mid [3];

    initial begin
        // Main run: sequential fetch, ready-wait at 8, stall, redirect with
        // stall, redirect during a wait, misaligned redirect, then HALTED.
        //          stl rv ra              hlt rdy rdata           pc           req nF nD inst            hlt cnt    err
        vecs[0]  = '{0, 0, 32'h0,          0, 1, 32'hDEAD_0000, 32'h0,        0, 1, 0, c_NOP,          0, 32'd0, 0};
        vecs[1]  = '{0, 0, 32'h0,          0, 1, 32'hA000_0000, 32'h0,        1, 0, 0, 32'hA000_0000,  0, 32'd0, 0};
        vecs[2]  = '{0, 0, 32'h0,          0, 1, 32'hA000_0004, 32'h4,        1, 0, 0, 32'hA000_0004,  0, 32'd1, 0};
        vecs[3]  = '{0, 0, 32'h0,          0, 0, 32'hBAD0_0008, 32'h8,        1, 1, 0, c_NOP,          0, 32'd2, 0};
        vecs[4]  = '{0, 0, 32'h0,          0, 0, 32'hBAD0_0008, 32'h8,        1, 1, 0, c_NOP,          0, 32'd2, 0};
        vecs[5]  = '{0, 0, 32'h0,          0, 0, 32'hBAD0_0008, 32'h8,        1, 1, 0, c_NOP,          0, 32'd2, 0};
        vecs[6]  = '{0, 0, 32'h0,          0, 1, 32'hA000_0008, 32'h8,        1, 0, 0, 32'hA000_0008,  0, 32'd2, 0};
        vecs[7]  = '{1, 0, 32'h0,          0, 1, 32'hA000_000C, 32'hC,        1, 0, 0, 32'hA000_000C,  0, 32'd3, 0};
        vecs[8]  = '{1, 1, 32'h40,         0, 1, 32'hA000_000C, 32'hC,        1, 1, 1, 32'hA000_000C,  0, 32'd3, 0};
        vecs[9]  = '{0, 0, 32'h0,          0, 1, 32'hB000_0040, 32'h40,       1, 0, 0, 32'hB000_0040,  0, 32'd3, 0};
        vecs[10] = '{0, 1, 32'h80,         0, 0, 32'hB000_0044, 32'h44,       1, 1, 1, c_NOP,          0, 32'd4, 0};
        vecs[11] = '{0, 1, 32'h42,         0, 1, 32'hC000_0080, 32'h80,       1, 1, 1, 32'hC000_0080,  0, 32'd4, 0};
        vecs[12] = '{0, 0, 32'h0,          0, 1, 32'hC000_0084, 32'h80,       0, 1, 0, c_NOP,          1, 32'd4, 1};
        vecs[13] = '{1, 1, 32'h100,        1, 1, 32'hC000_0088, 32'h80,       0, 1, 0, c_NOP,          1, 32'd4, 1};
        vecs[14] = '{0, 0, 32'h0,          0, 1, 32'hC000_008C, 32'h80,       0, 1, 0, c_NOP,          1, 32'd4, 1};

        // PC wrap at the top of the address space, then halt beating redirect.
        seq_wrap[0] = '{0, 0, 32'h0,         0, 1, 32'hDEAD_0000, 32'h0,        0, 1, 0, c_NOP,         0, 32'd0, 0};
        seq_wrap[1] = '{0, 1, 32'hFFFF_FFFC, 0, 0, 32'hDEAD_0001, 32'h0,        1, 1, 1, c_NOP,         0, 32'd0, 0};
        seq_wrap[2] = '{0, 0, 32'h0,         0, 1, 32'hD000_0000, 32'hFFFF_FFFC, 1, 0, 0, 32'hD000_0000, 0, 32'd0, 0};
        seq_wrap[3] = '{0, 1, 32'hFFFF_FFFC, 0, 0, 32'hDEAD_0002, 32'h0,        1, 1, 1, c_NOP,         0, 32'd1, 0};
        seq_wrap[4] = '{0, 1, 32'h200,       1, 1, 32'hD000_0004, 32'hFFFF_FFFC, 1, 1, 1, 32'hD000_0004, 0, 32'd1, 0};
        seq_wrap[5] = '{0, 0, 32'h0,         0, 1, 32'hD000_0008, 32'hFFFF_FFFC, 0, 1, 0, c_NOP,         1, 32'd1, 0};

        // Reset mid-wait: START repeats and the count restarts at zero.
        seq_mid[0] = '{0, 0, 32'h0, 0, 1, 32'hE000_0000, 32'h0, 0, 1, 0, c_NOP,         0, 32'd0, 0};
        seq_mid[1] = '{0, 0, 32'h0, 0, 1, 32'hE000_0000, 32'h0, 1, 0, 0, 32'hE000_0000, 0, 32'd0, 0};
        seq_mid[2] = '{0, 0, 32'h0, 0, 0, 32'hE000_0004, 32'h4, 1, 1, 0, c_NOP,         0, 32'd1, 0};

        RST = 1'b1;
        idle_inputs();
        @(negedge CLK);
        #1;
        do_reset("init");
        for (int i = 0; i < 15; i++) apply_vec($sformatf("main[%0d]", i), vecs[i]);

        do_reset("halted");
        for (int i = 0; i < 6; i++) apply_vec($sformatf("wrap[%0d]", i), seq_wrap[i]);

        do_reset("wrapdone");
        for (int i = 0; i < 3; i++) apply_vec($sformatf("mid[%0d]", i), seq_mid[i]);
        imem_ready = 1'b0;
        @(posedge CLK);
        #1;
        do_reset("midwait");
        apply_vec("restart[0]", seq_mid[0]);
        apply_vec("restart[1]", seq_mid[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0013, is the instruction word driven on bubbles.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  clock; all state updates occur on the falling edge.
REQ-005 RST  in  1  asynchronous active-low reset.
REQ-006 stall  in  1  hazard hold; PC is frozen.
REQ-007 redirect_valid  in  1  taken branch or jump resolved in EX.
REQ-008 redirect_addr  in  32  branch or jump target.
REQ-009 halt  in  1  halt reached writeback.
REQ-010 imem_ready  in  1  instruction memory returns imem_rdata for imem_addr this cycle.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 imem_req  out  1  fetch request.
REQ-013 imem_addr  out  32  fetch address, equal to PC.
REQ-014 PC_F  out  32  current PC.
REQ-015 PC_Plus4_F  out  32  PC+4.
REQ-016 InstWord_F  out  32  instruction passed to the IF/ID register.
REQ-017 nop_F  out  1  IF/ID loads a bubble.
REQ-018 nop_D  out  1  ID/EX loads a bubble (wrong-path squash).
REQ-019 halted  out  1  fetch permanently stopped.
REQ-020 addr_err  out  1  sticky misaligned-redirect flag.
REQ-021 fetch_count  out  32  count of accepted fetches.

Function
REQ-022 FSM states SHALL be START, FETCH and HALTED.
REQ-023 START SHALL last exactly one cycle after reset release, with imem_req=0 and nop_F=1, then move to FETCH.
REQ-024 In FETCH, imem_req=1, imem_addr=PC, PC_Plus4_F=PC+4 (mod 2^32), and InstWord_F=imem_rdata combinationally when imem_ready=1, otherwise NOP_WORD.
REQ-025 nop_F SHALL be combinational: 1 when not in FETCH, or imem_ready=0, or redirect_valid=1; otherwise 0.
REQ-026 nop_D SHALL equal redirect_valid while in FETCH, and 0 otherwise.
REQ-027 At each falling edge in FETCH, the first matching rule SHALL apply, in priority order: halt, redirect, stall, imem_ready advance, wait.
REQ-028 halt=1: go to HALTED; PC holds.
REQ-029 redirect_valid=1 with redirect_addr[1:0]=0: PC<=redirect_addr; this overrides stall and imem_ready in the same cycle.
REQ-030 redirect_valid=1 with redirect_addr[1:0]!=0: set addr_err=1 and go to HALTED; PC holds.
REQ-031 stall=1: PC holds; a word returned that cycle is discarded and refetched.
REQ-032 imem_ready=1: PC<=PC+4 with 32-bit wrap (32'hFFFF_FFFC advances to 0), and fetch_count increments by 1, also with wrap.
REQ-033 imem_ready=0: PC holds, imem_req stays 1, and imem_addr stays stable until ready.
REQ-034 fetch_count SHALL increment only on rule REQ-032, never on redirect, stall, or bubble.
REQ-035 HALTED SHALL drive imem_req=0, nop_F=1, nop_D=0, halted=1, and ignore all inputs; only reset exits it.
REQ-036 halted SHALL be a registered output, 1 exactly while in HALTED.

Reset
REQ-037 RST=0 SHALL immediately set: state=START, PC_F=RESET_PC, PC_Plus4_F=RESET_PC+4, fetch_count=0, addr_err=0, halted=0, imem_req=0, nop_F=1, nop_D=0.
REQ-038 Reset asserted mid-wait or while HALTED SHALL abandon the outstanding request with no further fetch_count change, and the START cycle SHALL repeat on release.

Verification
REQ-039 Reset release, imem_ready always 1 -> one START bubble, then PC_F=0,4,8,12 on successive cycles, and fetch_count=3 after the third advance.
REQ-040 imem_ready low for 3 cycles at PC=8 -> imem_addr=8 held, nop_F=1 for 3 cycles, then the word at 8 is passed and PC=12.
REQ-041 redirect_valid=1, redirect_addr=0x40, with stall=1 in the same cycle -> nop_F=1, nop_D=1, next PC=0x40, fetch_count unchanged.
REQ-042 redirect_addr=0x42 -> addr_err=1, halted=1, and imem_req=0 for all subsequent cycles until reset.
REQ-043 PC=0xFFFF_FFFC with ready=1 -> PC=0; with halt=1 and redirect_valid=1 together -> HALTED, PC holds.
